// File: rtl/man_decoding_master.sv
// man_decoding_master: Manchester receiver for the 7-bit ASI slave response
// frame (start 0, I3..I0 MSB first, even parity, end 1). Bit 1 is low-then-high,
// bit 0 is high-then-low, and the line idles high. Every sample point is timed
// from the synchronized falling edge in the middle of the start bit.
//
// Optional build macro RX_TIMEOUT_EN adds resp_arm / rx_timeout and a
// response timeout counter. Without it those ports and the counter are absent.

module man_decoding_master #(
  parameter int HALF_BIT_CLKS = 150
`ifdef RX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CLKS  = 2400
`endif
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       code_in,
  output logic [3:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [1:0] err_type,
  output logic       busy
`ifdef RX_TIMEOUT_EN
  ,
  input  logic       resp_arm,
  output logic       rx_timeout
`endif
);

  // Counter wide enough for the whole frame (last sample at 12.5 half-bits,
  // next sample target at 13.5 half-bits) without wrapping.
  localparam int CW = $clog2(14 * HALF_BIT_CLKS);

  localparam logic [CW-1:0] HALF_C  = CW'(HALF_BIT_CLKS / 2);
  localparam logic [CW-1:0] H_C     = CW'(HALF_BIT_CLKS);
  localparam logic [CW-1:0] RECOV_C = CW'(2 * HALF_BIT_CLKS - 1);
  localparam logic [CW-1:0] SAT_C   = {CW{1'b1}};

  // Sample index 12 is the second half of the end bit.
  localparam logic [3:0] LAST_IDX = 4'd12;

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    BITS,
    CHECK,
    RECOVER
  } state_t;

  // Synchronizer and edge-detect flops
  logic sync1_reg;
  logic s_reg;
  logic s_dly_reg;
  logic fall;

  // Decoder state
  state_t         state_reg,    state_next;
  logic [CW-1:0]  cnt_reg,      cnt_next;
  logic [CW-1:0]  pt_reg,       pt_next;
  logic [3:0]     idx_reg,      idx_next;
  logic           first_reg,    first_next;
  logic [5:0]     shift_reg,    shift_next;
  logic [CW-1:0]  cnt_inc;

  // Registered outputs
  logic [3:0]     rx_data_reg,  rx_data_next;
  logic           rx_valid_reg, rx_valid_next;
  logic           rx_err_reg,   rx_err_next;
  logic [1:0]     err_type_reg, err_type_next;

  // Two-flop synchronizer plus one delay flop; reset loads the idle level so
  // leaving reset never looks like a start edge.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      s_reg     <= 1'b1;
      s_dly_reg <= 1'b1;
    end else begin
      sync1_reg <= code_in;
      s_reg     <= sync1_reg;
      s_dly_reg <= s_reg;
    end
  end

  assign fall = s_dly_reg & ~s_reg;

  // Frame counter increments but sticks at all-ones instead of wrapping.
  assign cnt_inc = (cnt_reg == SAT_C) ? cnt_reg : cnt_reg + 1'b1;

  // Next-state and output decode for the frame FSM.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    pt_next       = pt_reg;
    idx_next      = idx_reg;
    first_next    = first_reg;
    shift_next    = shift_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    rx_err_next   = 1'b0;
    err_type_next = 2'd0;

    case (state_reg)
      IDLE: begin
        if (fall) begin
          // The edge cycle is t=0, so the next cycle holds t=1.
          state_next = START_CHK;
          cnt_next   = {{(CW-1){1'b0}}, 1'b1};
          pt_next    = HALF_C;
        end
      end

      START_CHK: begin
        cnt_next = cnt_inc;
        if (cnt_reg == pt_reg) begin
          if (!s_reg) begin
            state_next = BITS;
            idx_next   = 4'd1;
            pt_next    = pt_reg + H_C;
          end else begin
            // Line already back high: a glitch, drop it silently.
            state_next = IDLE;
          end
        end
      end

      BITS: begin
        cnt_next = cnt_inc;
        if (cnt_reg == pt_reg) begin
          pt_next  = pt_reg + H_C;
          idx_next = idx_reg + 4'd1;
          if (idx_reg[0]) begin
            // Odd index: first half of a bit, keep it for comparison.
            first_next = s_reg;
          end else if (s_reg == first_reg) begin
            // No mid-bit transition: Manchester violation.
            rx_err_next   = 1'b1;
            err_type_next = 2'd0;
            state_next    = RECOVER;
            cnt_next      = '0;
          end else begin
            // Bit value is the second-half level, shifted in MSB first.
            shift_next = {shift_reg[4:0], s_reg};
            if (idx_reg == LAST_IDX) begin
              state_next = CHECK;
            end
          end
        end
      end

      CHECK: begin
        // shift_reg = {I3, I2, I1, I0, P, END}; end bit outranks parity.
        if (!shift_reg[0]) begin
          rx_err_next   = 1'b1;
          err_type_next = 2'd2;
        end else if (^shift_reg[5:1]) begin
          rx_err_next   = 1'b1;
          err_type_next = 2'd1;
        end else begin
          rx_valid_next = 1'b1;
          rx_data_next  = shift_reg[5:2];
        end
        state_next = IDLE;
      end

      RECOVER: begin
        // Need 2H consecutive high samples; any low restarts the wait and
        // falling edges are not acted on here.
        if (!s_reg) begin
          cnt_next = '0;
        end else if (cnt_reg == RECOV_C) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Frame FSM state, datapath and output registers.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      pt_reg       <= '0;
      idx_reg      <= 4'd0;
      first_reg    <= 1'b0;
      shift_reg    <= 6'd0;
      rx_data_reg  <= 4'h0;
      rx_valid_reg <= 1'b0;
      rx_err_reg   <= 1'b0;
      err_type_reg <= 2'd0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      pt_reg       <= pt_next;
      idx_reg      <= idx_next;
      first_reg    <= first_next;
      shift_reg    <= shift_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      rx_err_reg   <= rx_err_next;
      err_type_reg <= err_type_next;
    end
  end

  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign rx_err   = rx_err_reg;
  assign err_type = err_type_reg;
  assign busy     = (state_reg != IDLE);

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);

  logic          arm_reg,  arm_next;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic          tout_reg, tout_next;

  // Response timeout: counts only in IDLE while armed, pauses during the
  // start check (a glitch keeps it armed) and disarms once bits are decoded.
  always_comb begin
    arm_next  = arm_reg;
    tcnt_next = tcnt_reg;
    tout_next = 1'b0;
    if (resp_arm && (state_reg == IDLE || arm_reg)) begin
      arm_next  = 1'b1;
      tcnt_next = {{(TW-1){1'b0}}, 1'b1};
    end else if (arm_reg) begin
      if (state_reg == START_CHK && state_next == BITS) begin
        arm_next = 1'b0;
      end else if (state_reg == IDLE && !fall) begin
        if (tcnt_reg == TO_LAST) begin
          tout_next = 1'b1;
          arm_next  = 1'b0;
        end else begin
          tcnt_next = tcnt_reg + 1'b1;
        end
      end
    end
  end

  // Timeout counter registers.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      arm_reg  <= 1'b0;
      tcnt_reg <= '0;
      tout_reg <= 1'b0;
    end else begin
      arm_reg  <= arm_next;
      tcnt_reg <= tcnt_next;
      tout_reg <= tout_next;
    end
  end

  assign rx_timeout = tout_reg;
`endif

endmodule

// File: tb/tb_man_decoding_master.sv
// tb_man_decoding_master: stimulus drives Manchester frames and pushes the
// expected outcome (event kind, value, cycle) into a queue; an independent
// monitor pops and compares whenever the decoder pulses an output.
// Build with RX_TIMEOUT_EN defined to also exercise the response timeout.

module tb_man_decoding_master;

  localparam int H  = 8;
  localparam int TO = 50;

  typedef struct {
    int kind;   // 0 = rx_valid, 1 = rx_err, 2 = rx_timeout
    int val;    // rx_data for valid, err_type for error
    int cyc;    // cycle count at which the pulse is expected
  } ev_t;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       code_in;
  logic [3:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [1:0] err_type;
  logic       busy;
  logic       tout_evt;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  exp_data = 0;
  ev_t exp_q[$];

`ifdef RX_TIMEOUT_EN
  logic resp_arm;
  logic rx_timeout;

  man_decoding_master #(.HALF_BIT_CLKS(H), .TIMEOUT_CLKS(TO)) dut (
    .clk_in(clk_in), .rst(rst), .code_in(code_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .err_type(err_type), .busy(busy),
    .resp_arm(resp_arm), .rx_timeout(rx_timeout)
  );
  assign tout_evt = rx_timeout;
`else
  man_decoding_master #(.HALF_BIT_CLKS(H)) dut (
    .clk_in(clk_in), .rst(rst), .code_in(code_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .err_type(err_type), .busy(busy)
  );
  assign tout_evt = 1'b0;
`endif

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    code_in = 1'b1;
    repeat (n) tick();
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  // Reference model. The line is sampled mid-half-bit: bit k halves sit at
  // (2k-1)H+H/2 and 2kH+H/2 after the synchronized start edge (t=0). The
  // synchronized edge is 2 cycles after code_in changes; a violation flags
  // one cycle after its sample, a completed frame is judged one cycle after
  // the last sample and reported the cycle after that.
  function automatic ev_t model(input logic [5:0] fh, input logic [5:0] sh, input int c0);
    ev_t e;
    bit  found;
    found = 1'b0;
    e.kind = 0; e.val = 0; e.cyc = 0;
    for (int k = 1; k <= 6; k++) begin
      if (!found && fh[6-k] == sh[6-k]) begin
        found  = 1'b1;
        e.kind = 1;
        e.val  = 0;
        e.cyc  = c0 + 2 + (2 * k * H + H / 2) + 1;
      end
    end
    if (!found) begin
      e.cyc = c0 + 2 + (12 * H + H / 2) + 2;
      if (sh[0] != 1'b1) begin
        e.kind = 1; e.val = 2;
      end else if ((sh[5] ^ sh[4] ^ sh[3] ^ sh[2] ^ sh[1]) != 1'b0) begin
        e.kind = 1; e.val = 1;
      end else begin
        e.kind = 0; e.val = int'(sh[5:2]);
      end
    end
    return e;
  endfunction

  // Sends a frame: start bit then bits 1..6 as (first half fh, second half sh),
  // index 5 = bit 1. abort_h < 13 aborts with a reset before that half.
  task automatic send_frame(input logic [5:0] fh, input logic [5:0] sh,
                            input int abort_h, input bit chk_busy, output int c0);
    ev_t e;
    code_in = 1'b1;
    repeat (H) tick();
    c0 = cyc;
    if (abort_h > 12) begin
      e = model(fh, sh, c0);
      exp_q.push_back(e);
    end
    for (int h = 0; h <= 12; h++) begin
      if (h == abort_h) begin
        code_in = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_data = 0;
        return;
      end
      if (h == 0)
        code_in = 1'b0;
      else if (h % 2 == 1)
        code_in = fh[6 - (h + 1) / 2];
      else
        code_in = sh[6 - h / 2];
      repeat (H) tick();
      if (chk_busy && h < 12) check("busy_in_frame", int'(busy), 1);
    end
    code_in = 1'b1;
  endtask

  function automatic logic [5:0] enc_bits(input logic [3:0] info, input logic p, input logic e);
    return {info, p, e};
  endfunction

  // Monitor: pops the expected event whenever the decoder pulses an output.
  always @(negedge clk_in) begin
    ev_t e;
    int  kact;
    check("valid_err_exclusive", int'(rx_valid & rx_err), 0);
    if (rx_valid || rx_err || tout_evt) begin
      kact = rx_valid ? 0 : (rx_err ? 1 : 2);
      $display("rx event: kind=%0d data=%0h err_type=%0d cycle=%0d", kact, rx_data, err_type, cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected no event", kact, cyc);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", kact, e.kind);
        check("event_cycle", cyc, e.cyc);
        if (e.kind == 0) begin
          check("rx_data", int'(rx_data), e.val);
          exp_data = e.val;
        end else if (e.kind == 1) begin
          check("err_type", int'(err_type), e.val);
          check("rx_data_held", int'(rx_data), exp_data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         c0;
    logic [5:0] sh;
    logic [5:0] fh;
`ifdef RX_TIMEOUT_EN
    int         ca;
    ev_t        te;
    resp_arm = 1'b0;
`endif
    rst = 1'b1;
    code_in = 1'b1;
    repeat (3) tick();
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_rx_err", int'(rx_err), 0);
    check("reset_err_type", int'(err_type), 0);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;
    idle(4 * H);

    // Valid frame 0xA, busy checked throughout
    sh = enc_bits(4'b1010, 1'b0, 1'b1);
    send_frame(~sh, sh, 99, 1'b1, c0);
    idle(4 * H);

    // Parity error: 0111 with P=0
    sh = enc_bits(4'b0111, 1'b0, 1'b1);
    send_frame(~sh, sh, 99, 1'b0, c0);
    idle(4 * H);

    // Manchester violation on I2 (both halves high), rest of frame all ones
    send_frame(6'b010000, 6'b111111, 99, 1'b0, c0);
    wait_until(c0 + 2 + 12 * H + 2 * H - 1);
    check("recover_busy_hold", int'(busy), 1);
    tick();
    check("recover_busy_release", int'(busy), 0);
    idle(4 * H);
    sh = enc_bits(4'h5, 1'b0, 1'b1);
    send_frame(~sh, sh, 99, 1'b0, c0);
    idle(4 * H);

    // Glitch: line low for 2 clocks
    c0 = cyc;
    code_in = 1'b0;
    tick();
    tick();
    code_in = 1'b1;
    wait_until(c0 + 2 + H / 2);
    check("glitch_busy_at_check", int'(busy), 1);
    tick();
    check("glitch_back_idle", int'(busy), 0);
    wait_until(c0 + 20 - H);
    sh = enc_bits(4'h3, 1'b0, 1'b1);
    send_frame(~sh, sh, 99, 1'b0, c0);
    check("glitch_frame_start", c0, cyc - 13 * H);
    idle(4 * H);

    // Reset during bit 3
    sh = enc_bits(4'hC, 1'b0, 1'b1);
    send_frame(~sh, sh, 6, 1'b0, c0);
    check("midrst_rx_data", int'(rx_data), 0);
    check("midrst_rx_valid", int'(rx_valid), 0);
    check("midrst_rx_err", int'(rx_err), 0);
    check("midrst_err_type", int'(err_type), 0);
    check("midrst_busy", int'(busy), 0);
    idle(16 * H);
    sh = enc_bits(4'hF, 1'b0, 1'b1);
    send_frame(~sh, sh, 99, 1'b0, c0);
    idle(4 * H);

`ifdef RX_TIMEOUT_EN
    // Armed with idle line: timeout exactly TO cycles after resp_arm
    ca = cyc;
    resp_arm = 1'b1;
    te.kind = 2; te.val = 0; te.cyc = ca + TO;
    exp_q.push_back(te);
    tick();
    resp_arm = 1'b0;
    idle(TO + 20);

    // Armed, frame starts 30 cycles later: no timeout, frame decodes
    ca = cyc;
    resp_arm = 1'b1;
    tick();
    resp_arm = 1'b0;
    wait_until(ca + 30 - H);
    sh = enc_bits(4'h9, 1'b0, 1'b1);
    send_frame(~sh, sh, 99, 1'b0, c0);
    check("timeout_frame_start", c0, ca + 30);
    idle(TO + 20);
`endif

    // Randomized frames: clean, parity flip, end-bit flip, Manchester violation
    for (int n = 0; n < 24; n++) begin
      int         mode;
      int         k;
      logic [3:0] info;
      logic       p;
      logic       e;
      mode = $urandom_range(0, 3);
      info = 4'($urandom_range(0, 15));
      p = ^info;
      e = 1'b1;
      if (mode == 1) p = ~p;
      if (mode == 2) e = 1'b0;
      sh = {info, p, e};
      fh = ~sh;
      if (mode == 3) begin
        k = $urandom_range(1, 6);
        fh[6-k] = 1'($urandom_range(0, 1));
        sh[6-k] = fh[6-k];
        for (int j = k + 1; j <= 6; j++) begin
          sh[6-j] = 1'b1;
          fh[6-j] = 1'b0;
        end
      end
      send_frame(fh, sh, 99, 1'b0, c0);
      idle(4 * H);
    end

    idle(20 * H);
    check("all_expected_events_seen", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
